// File: rtl/sprite_draw_sequencer.sv
// Per-frame sprite job scheduler: walks a small sprite table on each frame edge
// and issues one clipped copy_engine job per drawable slot via execute/done.
module sprite_draw_sequencer #(
  parameter int NumSlots     = 16,
  parameter int SrcAddrWidth = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_clk,
  input  logic                        wr_en,
  input  logic [$clog2(NumSlots)-1:0] wr_slot,
  input  logic                        wr_valid,
  input  logic [9:0]                  wr_x,
  input  logic [9:0]                  wr_y,
  input  logic [9:0]                  wr_w,
  input  logic [9:0]                  wr_h,
  input  logic [SrcAddrWidth-1:0]     wr_src_addr,
  input  logic                        wr_flip_x,
  input  logic                        done,
  output logic                        execute,
  output logic [9:0]                  dest_x_start,
  output logic [9:0]                  dest_x_end,
  output logic [9:0]                  dest_y_start,
  output logic [9:0]                  dest_y_end,
  output logic [SrcAddrWidth-1:0]     src_addr_start,
  output logic                        flip_x,
  output logic                        busy,
  output logic                        overrun
);

  localparam int SlotW = $clog2(NumSlots);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EXEC,
    S_RELEASE
  } state_t;

  state_t                  r_state;
  logic [SlotW-1:0]        r_slot;
  logic                    r_fc_q;

  logic                    r_execute;
  logic                    r_busy;
  logic                    r_overrun;
  logic [9:0]              r_dx0;
  logic [9:0]              r_dx1;
  logic [9:0]              r_dy0;
  logic [9:0]              r_dy1;
  logic [SrcAddrWidth-1:0] r_src;
  logic                    r_flip;

  logic                    r_tvalid [NumSlots];
  logic [9:0]              r_tx     [NumSlots];
  logic [9:0]              r_ty     [NumSlots];
  logic [9:0]              r_tw     [NumSlots];
  logic [9:0]              r_th     [NumSlots];
  logic [SrcAddrWidth-1:0] r_tsrc   [NumSlots];
  logic                    r_tflip  [NumSlots];

  logic                    w_frame_edge;
  logic                    w_last;
  logic                    w_drawable;

  // End coordinate is computed with a carry bit so x+w cannot wrap before clamping.
  function automatic logic [9:0] clip_end(input logic [9:0] start, input logic [9:0] len,
                                          input logic [10:0] limit);
    logic [10:0] sum;
    sum = {1'b0, start} + {1'b0, len};
    return (sum > limit) ? limit[9:0] : sum[9:0];
  endfunction

  assign w_frame_edge = frame_clk & ~r_fc_q;
  assign w_last       = (r_slot == SlotW'(NumSlots - 1));
  assign w_drawable   = r_tvalid[r_slot] && (r_tw[r_slot] != 10'd0) && (r_th[r_slot] != 10'd0)
                        && (r_tx[r_slot] < 10'd640) && (r_ty[r_slot] < 10'd480);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumSlots; i++) r_tvalid[i] <= 1'b0;
    end else if (wr_en) begin
      r_tvalid[wr_slot] <= wr_valid;
    end
  end

  // Sprite payload needs no reset: it is only consumed when its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tx[wr_slot]    <= wr_x;
      r_ty[wr_slot]    <= wr_y;
      r_tw[wr_slot]    <= wr_w;
      r_th[wr_slot]    <= wr_h;
      r_tsrc[wr_slot]  <= wr_src_addr;
      r_tflip[wr_slot] <= wr_flip_x;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_slot    <= '0;
      r_fc_q    <= 1'b0;
      r_execute <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_dx0     <= '0;
      r_dx1     <= '0;
      r_dy0     <= '0;
      r_dy1     <= '0;
      r_src     <= '0;
      r_flip    <= 1'b0;
    end else begin
      r_fc_q <= frame_clk;
      if (w_frame_edge && r_busy) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_frame_edge) begin
            r_slot  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_drawable) begin
            r_dx0     <= r_tx[r_slot];
            r_dx1     <= clip_end(r_tx[r_slot], r_tw[r_slot], 11'd640);
            r_dy0     <= r_ty[r_slot];
            r_dy1     <= clip_end(r_ty[r_slot], r_th[r_slot], 11'd480);
            r_src     <= r_tsrc[r_slot];
            r_flip    <= r_tflip[r_slot];
            r_execute <= 1'b1;
            r_state   <= S_EXEC;
          end else if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_slot <= r_slot + SlotW'(1);
          end
        end
        S_EXEC: begin
          if (done) begin
            r_execute <= 1'b0;
            r_state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Next job waits until copy_engine has dropped done.
          if (!done) begin
            if (w_last) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_slot  <= r_slot + SlotW'(1);
              r_state <= S_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign execute        = r_execute;
  assign busy           = r_busy;
  assign overrun        = r_overrun;
  assign dest_x_start   = r_dx0;
  assign dest_x_end     = r_dx1;
  assign dest_y_start   = r_dy0;
  assign dest_y_end     = r_dy1;
  assign src_addr_start = r_src;
  assign flip_x         = r_flip;

endmodule
